// File: rtl/trap_pkg.sv
// Shared types and constants for the interrupt trap sequencer.
//   trap_state_t  : sequencer FSM states
//   MRET_ENC      : instruction encoding of MRET
//   MTVEC_DEFAULT : default fixed trap vector
//   CNT_W         : width of the drain counter
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    VECTOR,
    HANDLER,
    RETURN
  } trap_state_t;

  localparam logic [31:0] MRET_ENC      = 32'h3020_0073;
  localparam logic [63:0] MTVEC_DEFAULT = 64'h0000_0000_0000_0100;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for the asynchronous interrupt request.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset, clears every stage
//   irq_req : asynchronous level request
//   irq_s   : synchronized request, SYNC_STAGES cycles behind irq_req
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_req,
  output logic irq_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_req};
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt entry/return sequencer.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   irq_req, irq_en     : async level request and global enable
//   fetch_pc            : PC fetch would issue next (resume point on entry)
//   ex_redirect_valid/pc: taken branch/jump resolved in EX
//   mret_retire         : MRET retires this cycle
//   stall_fetch, flush  : hold PC/IF, kill IF/ID
//   trap                : decoder irq input, suppresses branch PC selection
//   pc_redirect_valid/pc_redirect : PC load request and target
//   irq_ack             : one-cycle entry pulse
//   in_handler          : vector cycle through the return cycle
//   mepc                : saved resume PC
module irq_trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] MTVEC        = XLEN'(MTVEC_DEFAULT),
  parameter int unsigned     DRAIN_CYCLES = 3,
  parameter int unsigned     SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_req,
  input  logic            irq_en,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            ex_redirect_valid,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            mret_retire,
  output logic            stall_fetch,
  output logic            trap,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect,
  output logic            flush,
  output logic            irq_ack,
  output logic            in_handler,
  output logic [XLEN-1:0] mepc
);

  trap_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic             irq_s;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .irq_req(irq_req),
    .irq_s  (irq_s)
  );

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mepc_d            = mepc_q;
    stall_fetch       = 1'b0;
    trap              = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = '0;
    flush             = 1'b0;
    irq_ack           = 1'b0;
    in_handler        = 1'b0;

    case (state_q)
      IDLE: begin
        if (irq_s && irq_en) begin
          mepc_d  = fetch_pc;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall_fetch = 1'b1;
        // Older instructions still complete; a taken branch among them moves the resume point.
        if (ex_redirect_valid) begin
          mepc_d = ex_redirect_pc;
        end
        if (cnt_q == '0) begin
          state_d = VECTOR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      VECTOR: begin
        stall_fetch       = 1'b1;
        trap              = 1'b1;
        flush             = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = MTVEC;
        irq_ack           = 1'b1;
        in_handler        = 1'b1;
        state_d           = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (mret_retire) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        trap              = 1'b1;
        flush             = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = mepc_q;
        in_handler        = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mepc_q  <= mepc_d;
    end
  end

  assign mepc = mepc_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Directed and randomized bench for irq_trap_sequencer, checked every cycle against a
// timeline model (cycles since acceptance) plus directed constant checks.
module tb_irq_trap_sequencer;

  localparam int          XLEN = 64;
  localparam int          D    = 3;
  localparam int          S    = 2;
  localparam logic [63:0] VEC  = 64'h100;

  logic            clk = 1'b0;
  logic            rst, irq_req, irq_en, ex_redirect_valid, mret_retire;
  logic [XLEN-1:0] fetch_pc, ex_redirect_pc;
  logic            stall_fetch, trap, pc_redirect_valid, flush, irq_ack, in_handler;
  logic [XLEN-1:0] pc_redirect, mepc;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_age = -1 when idle, else cycles since acceptance (0..D-1 drain, D vector,
  // D+1 handler); m_ret marks the one return cycle. m_seen holds past irq_req samples.
  int          m_age;
  bit          m_ret;
  logic [63:0] m_mepc;
  logic [S-1:0] m_seen;

  always #5 clk = ~clk;

  irq_trap_sequencer #(
    .XLEN        (XLEN),
    .MTVEC       (VEC),
    .DRAIN_CYCLES(D),
    .SYNC_STAGES (S)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_req          (irq_req),
    .irq_en           (irq_en),
    .fetch_pc         (fetch_pc),
    .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_pc   (ex_redirect_pc),
    .mret_retire      (mret_retire),
    .stall_fetch      (stall_fetch),
    .trap             (trap),
    .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect      (pc_redirect),
    .flush            (flush),
    .irq_ack          (irq_ack),
    .in_handler       (in_handler),
    .mepc             (mepc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit irq_seen;
    if (rst) begin
      m_age  = -1;
      m_ret  = 1'b0;
      m_mepc = '0;
      m_seen = '0;
    end else begin
      // Request visible S edges after it was sampled.
      irq_seen = m_seen[S-1];
      if (m_ret) begin
        m_ret = 1'b0;
        m_age = -1;
      end else if (m_age < 0) begin
        if (irq_seen && irq_en) begin
          m_age  = 0;
          m_mepc = fetch_pc;
        end
      end else if (m_age < D) begin
        if (ex_redirect_valid) m_mepc = ex_redirect_pc;
        m_age++;
      end else if (m_age == D) begin
        m_age = D + 1;
      end else if (mret_retire) begin
        m_ret = 1'b1;
      end
      m_seen = {m_seen[S-2:0], irq_req};
    end
  endtask

  task automatic check_all();
    bit vec, drain, redir;
    logic [63:0] exp_pc;
    drain  = (m_age >= 0) && (m_age < D);
    vec    = (m_age == D);
    redir  = vec || m_ret;
    exp_pc = vec ? VEC : (m_ret ? m_mepc : 64'h0);
    chk("m_stall", stall_fetch, 64'(drain || vec));
    chk("m_trap", trap, 64'(redir));
    chk("m_flush", flush, 64'(redir));
    chk("m_prv", pc_redirect_valid, 64'(redir));
    chk("m_pc", pc_redirect, exp_pc);
    chk("m_ack", irq_ack, 64'(vec));
    chk("m_inh", in_handler, 64'(m_age >= D));
    chk("m_mepc", mepc, m_mepc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (irq_ack === 1'b1) break;
      tick();
    end
    chk(tag, irq_ack, 1);
  endtask

  task automatic wait_stall(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (stall_fetch === 1'b1) break;
      tick();
    end
    chk(tag, stall_fetch, 1);
  endtask

  initial begin
    int n;
    m_age = -1; m_ret = 1'b0; m_mepc = '0; m_seen = '0;
    rst = 1'b1; irq_req = 1'b0; irq_en = 1'b0; fetch_pc = '0;
    ex_redirect_valid = 1'b0; ex_redirect_pc = '0; mret_retire = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_stall", stall_fetch, 0);
    chk("rst_mepc", mepc, 0);

    // Basic entry and return.
    irq_req = 1'b1; irq_en = 1'b1; fetch_pc = 64'h2000;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (irq_ack === 1'b1) break;
      if (stall_fetch === 1'b1) n++;
      tick();
    end
    chk("basic_ack", irq_ack, 1);
    chk("basic_drain_len", 64'(n), 64'(D));
    chk("basic_vec_pc", pc_redirect, 64'h100);
    chk("basic_mepc", mepc, 64'h2000);
    irq_req = 1'b0;
    tick();
    chk("basic_handler", in_handler, 1);
    mret_retire = 1'b1;
    tick();
    chk("basic_ret_pc", pc_redirect, 64'h2000);
    mret_retire = 1'b0;
    tick();
    chk("basic_idle", in_handler, 0);

    // Masked interrupt, then unmask with the synchronized request already high.
    irq_en = 1'b0; irq_req = 1'b1;
    repeat (20) tick();
    chk("masked_stall", stall_fetch, 0);
    irq_en = 1'b1;
    tick();
    chk("unmask_drain", stall_fetch, 1);
    irq_req = 1'b0;
    wait_ack("unmask_ack");
    tick();
    mret_retire = 1'b1; tick(); mret_retire = 1'b0; tick();

    // Redirect on drain cycle 2 moves mepc; redirect during vector is ignored.
    fetch_pc = 64'h3000; irq_req = 1'b1;
    wait_stall("redir_drain");
    irq_req = 1'b0;
    tick();
    ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h4000;
    tick();
    ex_redirect_valid = 1'b0;
    wait_ack("redir_ack");
    ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h9999;
    tick();
    ex_redirect_valid = 1'b0;
    chk("redir_mepc", mepc, 64'h4000);
    mret_retire = 1'b1; tick();
    chk("redir_ret_pc", pc_redirect, 64'h4000);
    mret_retire = 1'b0; tick();

    // Held request: no nesting, one IDLE cycle before re-entry.
    fetch_pc = 64'h6000; irq_req = 1'b1;
    wait_ack("nest_ack");
    repeat (6) tick();
    chk("nest_no_ack", irq_ack, 0);
    mret_retire = 1'b1; tick(); mret_retire = 1'b0;
    fetch_pc = 64'h5000;
    chk("nest_ret_ack", irq_ack, 0);
    tick();
    chk("nest_idle_stall", stall_fetch, 0);
    tick();
    chk("nest_reentry", stall_fetch, 1);
    chk("nest_mepc", mepc, 64'h5000);
    irq_req = 1'b0;

    // Reset during DRAIN, then during HANDLER.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstd_stall", stall_fetch, 0);
    chk("rstd_mepc", mepc, 0);
    fetch_pc = 64'h7001; irq_req = 1'b1;
    wait_ack("rsth_ack");
    chk("rsth_mepc", mepc, 64'h7001);
    irq_req = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rsth_inh", in_handler, 0);
    chk("rsth_mepc0", mepc, 0);

    // Spurious MRET in IDLE, then a single-cycle request pulse.
    repeat (3) tick();
    mret_retire = 1'b1; tick(); mret_retire = 1'b0;
    chk("spur_mret", pc_redirect_valid, 0);
    fetch_pc = 64'h8000; irq_req = 1'b1; tick(); irq_req = 1'b0;
    wait_ack("pulse_ack");
    chk("pulse_mepc", mepc, 64'h8000);
    tick();
    mret_retire = 1'b1; tick(); mret_retire = 1'b0; tick();

    // Randomized traffic.
    repeat (600) begin
      rst               = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) irq_req = ~irq_req;
      irq_en            = ($urandom_range(3) != 0);
      fetch_pc          = {$urandom, $urandom};
      ex_redirect_valid = $urandom_range(1) == 1;
      ex_redirect_pc    = {$urandom, $urandom};
      mret_retire       = ($urandom_range(5) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
